// File: rtl/reg_serial_tx_if.sv
// Parallel-in handshake and serial-out status bundle for reg_serial_tx.
interface reg_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              tx_out;
  logic              busy;
  logic              done;

  modport master (
    output din, din_valid,
    input  din_ready, tx_out, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, tx_out, busy, done
  );
endinterface

// File: rtl/reg_serial_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each held for CLKS_PER_BIT enabled cycles.
//
//   state | meaning
//   IDLE  | line high, waiting for a word
//   START | line low for one bit time
//   DATA  | line carries shift register bit 0
//   STOP  | line high for one bit time
module reg_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic           clk,
  input logic           rst,
  input logic           en,
  reg_serial_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] CYC_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [4:0] BIT_LAST = 5'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [7:0]        cyc_q, cyc_d;
  logic [4:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              done_evt;
  logic              cyc_last;
  logic              accept;

  assign bus.din_ready = (state_q == IDLE) && en && rst;
  assign accept        = bus.din_valid && bus.din_ready;
  assign cyc_last      = (cyc_q == CYC_LAST);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    done_evt = 1'b0;
    tx_d     = 1'b1;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_d = bus.din;
            cyc_d   = '0;
            bit_d   = '0;
            state_d = START;
          end
        end
        START: begin
          if (cyc_last) begin
            cyc_d   = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            cyc_d = cyc_q + 8'd1;
          end
        end
        DATA: begin
          if (cyc_last) begin
            cyc_d   = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end else begin
            cyc_d = cyc_q + 8'd1;
          end
        end
        STOP: begin
          if (cyc_last) begin
            cyc_d    = '0;
            state_d  = IDLE;
            done_evt = 1'b1;
          end else begin
            cyc_d = cyc_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Line level follows the state being entered so tx_out is registered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = en ? done_evt : done_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;
  // A completion that lands while disabled waits for the next enabled cycle.
  assign bus.done   = done_q && en;

endmodule

// File: tb/tb_reg_serial_tx.sv
// Bench for reg_serial_tx: two instances (4 and 1 clocks per bit) share stimulus
// and are checked every cycle against a frame-position reference model.
module tb_reg_serial_tx;

  localparam int DW = 8;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          en        = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din       = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_serial_tx_if #(.DATA_W(DW)) bus4 ();
  reg_serial_tx_if #(.DATA_W(DW)) bus1 ();

  assign bus4.din       = din;
  assign bus4.din_valid = din_valid;
  assign bus1.din       = din;
  assign bus1.din_valid = din_valid;

  reg_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .bus(bus4)
  );
  reg_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .bus(bus1)
  );

  typedef struct {
    bit            active;
    int            k;
    logic [DW-1:0] word;
    bit            done_flag;
  } model_t;

  localparam model_t M_RST = '{1'b0, 0, 8'h00, 1'b0};
  model_t m4 = M_RST;
  model_t m1 = M_RST;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame position k counts enabled cycles since the first start cycle.
  function automatic model_t m_step(model_t m, int cpb, logic e, logic v, logic [DW-1:0] d);
    model_t r = m;
    if (!e) return r;
    r.done_flag = 1'b0;
    if (!r.active) begin
      if (v) begin
        r.active = 1'b1;
        r.k      = 0;
        r.word   = d;
      end
    end else begin
      r.k++;
      if (r.k == (DW + 2) * cpb) begin
        r.active    = 1'b0;
        r.done_flag = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic m_tx(model_t m, int cpb);
    int b;
    if (!m.active) return 1'b1;
    b = m.k / cpb;
    if (b == 0) return 1'b0;
    if (b <= DW) return m.word[b-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_tx4", bus4.tx_out, 1);    chk("rst_busy4", bus4.busy, 0);
      chk("rst_done4", bus4.done, 0);    chk("rst_rdy4", bus4.din_ready, 0);
      chk("rst_tx1", bus1.tx_out, 1);    chk("rst_busy1", bus1.busy, 0);
      m4 = M_RST;
      m1 = M_RST;
    end else begin
      chk("tx4", bus4.tx_out, m_tx(m4, 4));
      chk("busy4", bus4.busy, m4.active);
      chk("done4", bus4.done, m4.done_flag && en);
      chk("rdy4", bus4.din_ready, !m4.active && en);
      chk("tx1", bus1.tx_out, m_tx(m1, 1));
      chk("busy1", bus1.busy, m1.active);
      chk("done1", bus1.done, m1.done_flag && en);
      chk("rdy1", bus1.din_ready, !m1.active && en);
      m4 = m_step(m4, 4, en, din_valid, din);
      m1 = m_step(m1, 1, en, din_valid, din);
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    logic [9:0]    frame;
    int            busy4;
    int            done4;
    int            busy1;
    int            done1;
  } vec_t;

  typedef struct {
    logic [9:0] f4, f1;
    int b4, b1, d4, d1, nd4, nd1, rb4;
  } cap_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (bus4.busy || bus1.busy); i++) tick();
    chk("wait_idle", bus4.busy | bus1.busy, 0);
  endtask

  task automatic send(input logic [DW-1:0] w);
    wait_idle();
    en        = 1'b1;
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Entered in the first start cycle; samples mid-bit on the 4-clock instance.
  task automatic capture(input bit scr, output cap_t r);
    r = '{10'h0, 10'h0, 0, 0, -1, -1, 0, 0, 0};
    for (int c = 0; c < 48; c++) begin
      if (scr) begin
        din_valid = (c < 36);
        din       = DW'($urandom);
      end
      @(negedge clk);
      if (c % 4 == 2 && c / 4 < 10) r.f4[c/4] = bus4.tx_out;
      if (c < 10) r.f1[c] = bus1.tx_out;
      if (bus4.busy) r.b4++;
      if (bus1.busy) r.b1++;
      if (bus4.done) begin r.nd4++; if (r.d4 < 0) r.d4 = c; end
      if (bus1.done) begin r.nd1++; if (r.d1 < 0) r.d1 = c; end
      if (bus4.busy && bus4.din_ready) r.rb4++;
      tick();
    end
    din_valid = 1'b0;
  endtask

  vec_t vecs[6];
  cap_t r;

  initial begin
    int cnt, nd, b, bad;
    bit found;

    vecs[0] = '{8'h15, 10'b1_00010101_0, 40, 40, 10, 10};
    vecs[1] = '{8'hA5, 10'b1_10100101_0, 40, 40, 10, 10};
    vecs[2] = '{8'h3C, 10'b1_00111100_0, 40, 40, 10, 10};
    vecs[3] = '{8'hFF, 10'b1_11111111_0, 40, 40, 10, 10};
    vecs[4] = '{8'h00, 10'b1_00000000_0, 40, 40, 10, 10};
    vecs[5] = '{8'h81, 10'b1_10000001_0, 40, 40, 10, 10};

    #1 rst = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    #1;
    chk("reset_tx4", bus4.tx_out, 1);
    chk("reset_busy4", bus4.busy, 0);
    chk("reset_done4", bus4.done, 0);
    chk("reset_rdy4", bus4.din_ready, 0);
    rst = 1'b1;
    tick();
    chk("post_reset_rdy4", bus4.din_ready, 1);
    tick();

    foreach (vecs[i]) begin
      send(vecs[i].d);
      capture(1'b0, r);
      chk($sformatf("frame4_%0h", vecs[i].d), r.f4, vecs[i].frame);
      chk($sformatf("frame1_%0h", vecs[i].d), r.f1, vecs[i].frame);
      chk($sformatf("busy4_%0h", vecs[i].d), r.b4, vecs[i].busy4);
      chk($sformatf("donepos4_%0h", vecs[i].d), r.d4, vecs[i].done4);
      chk($sformatf("busy1_%0h", vecs[i].d), r.b1, vecs[i].busy1);
      chk($sformatf("donepos1_%0h", vecs[i].d), r.d1, vecs[i].done1);
      chk($sformatf("ndone4_%0h", vecs[i].d), r.nd4, 1);
      chk($sformatf("ndone1_%0h", vecs[i].d), r.nd1, 1);
    end

    // back-to-back: next word offered in the done cycle
    send(8'hA5);
    found = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      cnt++;
      if (bus4.done) found = 1'b1;
    end
    chk("b2b_done_seen", found, 1);
    chk("b2b_done_pos", cnt, 40);
    chk("b2b_gap_tx", bus4.tx_out, 1);
    chk("b2b_gap_busy", bus4.busy, 0);
    chk("b2b_gap_rdy", bus4.din_ready, 1);
    din       = 8'h3C;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("b2b_start_tx", bus4.tx_out, 0);
    chk("b2b_start_busy", bus4.busy, 1);
    capture(1'b0, r);
    chk("b2b_frame", r.f4, 10'b1_00111100_0);

    // en low for 7 cycles inside data bit 3
    send(8'hFF);
    b = 0; nd = 0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      en = !(c >= 18 && c < 25);
      @(negedge clk);
      if (bus4.busy) b++;
      if (bus4.done) nd++;
      if (!en && (bus4.tx_out !== 1'b1 || bus4.done !== 1'b0)) bad++;
      tick();
    end
    en = 1'b1;
    chk("pause_busy_len", b, 47);
    chk("pause_done_cnt", nd, 1);
    chk("pause_hold", bad, 0);

    // reset during data of a zero frame
    send(8'h00);
    repeat (10) tick();
    chk("abort_pre_tx", bus4.tx_out, 0);
    rst = 1'b0;
    #1;
    chk("abort_tx", bus4.tx_out, 1);
    chk("abort_busy", bus4.busy, 0);
    chk("abort_rdy", bus4.din_ready, 0);
    tick();
    rst = 1'b1;
    nd  = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus4.done) nd++;
      tick();
    end
    chk("abort_no_done", nd, 0);
    send(8'h5A);
    capture(1'b0, r);
    chk("after_abort_frame4", r.f4, 10'b1_01011010_0);
    chk("after_abort_frame1", r.f1, 10'b1_01011010_0);

    // din churns while busy
    send(8'hC3);
    capture(1'b1, r);
    chk("churn_frame4", r.f4, 10'b1_11000011_0);
    chk("churn_frame1", r.f1, 10'b1_11000011_0);
    chk("churn_rdy_busy", r.rb4, 0);
    chk("churn_busy4", r.b4, 40);

    // random traffic against the model
    wait_idle();
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      din_valid = 1'($urandom_range(0, 1));
      din       = DW'($urandom);
      rst       = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst       = 1'b1;
    en        = 1'b1;
    din_valid = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
